// File: rtl/mhsa_pkg.sv
// Shared types and helpers for the MHSA stage sequencer and its bar multiplexer.
package mhsa_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone, StErr} seq_state_e;

    localparam int unsigned MAX_STAGES     = 32;
    localparam int unsigned DEF_NUM_STAGES = 5;
    localparam logic [19:0] DEF_BAR_OWN    = 20'h9E37F;

    // Index width, never narrower than one bit.
    function automatic int unsigned stg_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned STG_W = stg_w(DEF_NUM_STAGES);

    typedef struct packed {
        logic        valid;
        logic [31:0] idx;
    } stage_sel_t;

    // Lowest set bit of mask at or above from_idx.
    function automatic stage_sel_t first_en(input logic [MAX_STAGES-1:0] mask,
                                            input int unsigned from_idx);
        stage_sel_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = MAX_STAGES - 1; i >= 0; i--) begin
            if (i >= int'(from_idx) && mask[i]) begin
                r.valid = 1'b1;
                r.idx   = 32'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mhsa_bar_mux.sv
// Ownership-gated multiplexer: routes the selected stage onto each shared SRAM bar.
module mhsa_bar_mux import mhsa_pkg::*; #(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter int unsigned NUM_BARS   = 4,
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned ADDR_W     = 32,
    parameter logic [NUM_STAGES*NUM_BARS-1:0] BAR_OWN = DEF_BAR_OWN,
    localparam int unsigned IdxW = stg_w(NUM_STAGES)
) (
    input  logic [IdxW-1:0]                       sel_i,
    input  logic                                  valid_i,
    input  logic [NUM_STAGES*NUM_BARS-1:0]        stg_we_i,
    input  logic [NUM_STAGES*NUM_BARS*WIDTH-1:0]  stg_wdata_i,
    input  logic [NUM_STAGES*NUM_BARS*ADDR_W-1:0] stg_addr_i,
    output logic [NUM_BARS-1:0]                   bar_we_o,
    output logic [NUM_BARS*WIDTH-1:0]             bar_wdata_o,
    output logic [NUM_BARS*ADDR_W-1:0]            bar_addr_o
);

    always_comb begin
        bar_we_o    = '0;
        bar_wdata_o = '0;
        bar_addr_o  = '0;
        for (int unsigned b = 0; b < NUM_BARS; b++) begin
            for (int unsigned s = 0; s < NUM_STAGES; s++) begin
                if (valid_i && sel_i == IdxW'(s) && BAR_OWN[s*NUM_BARS+b]) begin
                    bar_we_o[b]                  = stg_we_i[s*NUM_BARS+b];
                    bar_wdata_o[b*WIDTH +: WIDTH] = stg_wdata_i[(s*NUM_BARS+b)*WIDTH +: WIDTH];
                    bar_addr_o[b*ADDR_W +: ADDR_W] =
                        stg_addr_i[(s*NUM_BARS+b)*ADDR_W +: ADDR_W];
                end
            end
        end
    end

endmodule

// File: rtl/mhsa_stage_seq.sv
// Sequences the MHSA compute stages in index order with skip mask, abort, watchdog and
// cycle counter, and arbitrates the shared SRAM bars to the active stage.
module mhsa_stage_seq import mhsa_pkg::*; #(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter int unsigned NUM_BARS   = 4,
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned TO_W       = 24,
    parameter logic [NUM_STAGES*NUM_BARS-1:0] BAR_OWN = DEF_BAR_OWN,
    localparam int unsigned IdxW = stg_w(NUM_STAGES)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start_i,
    input  logic                                  abort_i,
    input  logic [NUM_STAGES-1:0]                 stage_en_i,
    input  logic [TO_W-1:0]                       timeout_cycles_i,
    output logic                                  done_o,
    output logic                                  busy_o,
    output logic                                  error_o,
    output logic [IdxW-1:0]                       err_stage_o,
    output logic [IdxW-1:0]                       cur_stage_o,
    output logic [31:0]                           run_cycles_o,
    output logic [NUM_STAGES-1:0]                 stg_start_o,
    input  logic [NUM_STAGES-1:0]                 stg_done_i,
    input  logic [NUM_STAGES*NUM_BARS-1:0]        stg_we_i,
    input  logic [NUM_STAGES*NUM_BARS*WIDTH-1:0]  stg_wdata_i,
    input  logic [NUM_STAGES*NUM_BARS*ADDR_W-1:0] stg_addr_i,
    output logic [NUM_BARS-1:0]                   bar_we_o,
    output logic [NUM_BARS*WIDTH-1:0]             bar_wdata_o,
    output logic [NUM_BARS*ADDR_W-1:0]            bar_addr_o
);

    seq_state_e            state_q, state_d;
    logic [NUM_STAGES-1:0] en_q, en_d;
    logic [IdxW-1:0]       cur_q, cur_d;
    logic [IdxW-1:0]       err_stage_q, err_stage_d;
    logic [31:0]           run_cycles_q, run_cycles_d;
    logic [TO_W-1:0]       wdog_q, wdog_d;
    logic                  rearm_q, rearm_d;

    stage_sel_t first_sel, next_sel;
    logic       cur_done, wdog_hit;

    assign first_sel = first_en(32'(stage_en_i), 32'd0);
    assign next_sel  = first_en(32'(en_q), 32'(cur_q) + 32'd1);
    assign cur_done  = stg_done_i[cur_q];
    assign wdog_hit  = (timeout_cycles_i != '0) && (wdog_q == timeout_cycles_i - TO_W'(1));

    always_comb begin
        state_d      = state_q;
        en_d         = en_q;
        cur_d        = cur_q;
        err_stage_d  = err_stage_q;
        run_cycles_d = run_cycles_q;
        wdog_d       = wdog_q;
        rearm_d      = rearm_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    en_d         = stage_en_i;
                    run_cycles_d = '0;
                    wdog_d       = '0;
                    err_stage_d  = '0;
                    cur_d        = IdxW'(first_sel.idx);
                    state_d      = first_sel.valid ? StRun : StDone;
                end
            end
            StRun: begin
                if (run_cycles_q != '1) run_cycles_d = run_cycles_q + 32'd1;
                // abort beats stage completion, which beats the watchdog
                if (abort_i) begin
                    state_d = StIdle;
                end else if (cur_done) begin
                    if (next_sel.valid) begin
                        cur_d  = IdxW'(next_sel.idx);
                        wdog_d = '0;
                    end else begin
                        state_d = StDone;
                    end
                end else if (wdog_hit) begin
                    state_d     = StErr;
                    err_stage_d = cur_q;
                    rearm_d     = 1'b0;
                end else begin
                    wdog_d = wdog_q + TO_W'(1);
                end
            end
            StDone: begin
                if (abort_i || !start_i) state_d = StIdle;
            end
            StErr: begin
                // a fresh start edge (low then high) is needed to leave the error
                if (abort_i) begin
                    state_d = StIdle;
                end else if (!start_i) begin
                    rearm_d = 1'b1;
                end else if (rearm_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            en_q         <= '0;
            cur_q        <= '0;
            err_stage_q  <= '0;
            run_cycles_q <= '0;
            wdog_q       <= '0;
            rearm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            cur_q        <= cur_d;
            err_stage_q  <= err_stage_d;
            run_cycles_q <= run_cycles_d;
            wdog_q       <= wdog_d;
            rearm_q      <= rearm_d;
        end
    end

    assign busy_o       = (state_q == StRun);
    assign done_o       = (state_q == StDone);
    assign error_o      = (state_q == StErr);
    assign err_stage_o  = err_stage_q;
    assign cur_stage_o  = cur_q;
    assign run_cycles_o = run_cycles_q;
    assign stg_start_o  = busy_o ? (NUM_STAGES'(1) << cur_q) : '0;

    mhsa_bar_mux #(
        .NUM_STAGES (NUM_STAGES),
        .NUM_BARS   (NUM_BARS),
        .WIDTH      (WIDTH),
        .ADDR_W     (ADDR_W),
        .BAR_OWN    (BAR_OWN)
    ) u_bar_mux (
        .sel_i       (cur_q),
        .valid_i     (busy_o),
        .stg_we_i    (stg_we_i),
        .stg_wdata_i (stg_wdata_i),
        .stg_addr_i  (stg_addr_i),
        .bar_we_o    (bar_we_o),
        .bar_wdata_o (bar_wdata_o),
        .bar_addr_o  (bar_addr_o)
    );

endmodule

// File: tb/tb_mhsa_stage_seq.sv
// Bench for mhsa_stage_seq: per-cycle reference model comparison plus directed scenarios.
module tb_mhsa_stage_seq;

    localparam int NS = 5, NB = 4, W = 64, AW = 32, TOW = 24;
    localparam logic [NS*NB-1:0] OWN = 20'h9E37F;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [NS-1:0]       stage_en = '0, stg_done = '0, stg_start_o;
    logic [TOW-1:0]      to = '0;
    logic                done_o, busy_o, error_o;
    logic [2:0]          err_stage_o, cur_stage_o;
    logic [31:0]         run_cycles_o;
    logic [NS*NB-1:0]    stg_we = '0;
    logic [NS*NB*W-1:0]  stg_wdata = '0;
    logic [NS*NB*AW-1:0] stg_addr = '0;
    logic [NB-1:0]       bar_we_o;
    logic [NB*W-1:0]     bar_wdata_o;
    logic [NB*AW-1:0]    bar_addr_o;

    mhsa_stage_seq #(
        .NUM_STAGES (NS), .NUM_BARS (NB), .WIDTH (W), .ADDR_W (AW), .TO_W (TOW), .BAR_OWN (OWN)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start_i (start), .abort_i (abort),
        .stage_en_i (stage_en), .timeout_cycles_i (to), .done_o (done_o), .busy_o (busy_o),
        .error_o (error_o), .err_stage_o (err_stage_o), .cur_stage_o (cur_stage_o),
        .run_cycles_o (run_cycles_o), .stg_start_o (stg_start_o), .stg_done_i (stg_done),
        .stg_we_i (stg_we), .stg_wdata_i (stg_wdata), .stg_addr_i (stg_addr),
        .bar_we_o (bar_we_o), .bar_wdata_o (bar_wdata_o), .bar_addr_o (bar_addr_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model: phase of the run, active stage, cycles spent in that stage.
    typedef enum int {MIdle, MRun, MDone, MErr} mph_e;
    mph_e        m_ph = MIdle;
    int          m_stage = 0, m_wd = 0, m_errst = 0;
    logic [31:0] m_cyc = '0;
    logic [NS-1:0] m_en = '0;
    bit          m_low = 1'b0;

    function automatic int next_on(logic [NS-1:0] en, int from);
        for (int i = from; i < NS; i++) if (en[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [NS-1:0] exp_start;
        bit            own;
        int            nx;
        #1;
        if (!rst_n) begin
            m_ph = MIdle; m_stage = 0; m_wd = 0; m_errst = 0; m_cyc = '0; m_en = '0;
        end
        exp_start = '0;
        if (m_ph == MRun) exp_start[m_stage] = 1'b1;
        chk("busy", busy_o, m_ph == MRun);
        chk("done", done_o, m_ph == MDone);
        chk("error", error_o, m_ph == MErr);
        chk("cur_stage", cur_stage_o, m_stage);
        chk("err_stage", err_stage_o, m_errst);
        chk("run_cycles", run_cycles_o, m_cyc);
        chk("stg_start", stg_start_o, exp_start);
        for (int b = 0; b < NB; b++) begin
            own = (m_ph == MRun) && OWN[m_stage*NB+b];
            chk("bar_we", bar_we_o[b], own ? stg_we[m_stage*NB+b] : 1'b0);
            chk("bar_wdata", bar_wdata_o[b*W +: W], own ? stg_wdata[(m_stage*NB+b)*W +: W] : '0);
            chk("bar_addr", bar_addr_o[b*AW +: AW], own ? stg_addr[(m_stage*NB+b)*AW +: AW] : '0);
        end
        if (rst_n) begin
            case (m_ph)
                MIdle: if (start && !abort) begin
                    m_en = stage_en; m_cyc = '0; m_wd = 0; m_errst = 0;
                    m_stage = next_on(stage_en, 0);
                    if (m_stage < 0) begin m_stage = 0; m_ph = MDone; end
                    else m_ph = MRun;
                end
                MRun: begin
                    if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
                    if (abort) m_ph = MIdle;
                    else if (stg_done[m_stage]) begin
                        nx = next_on(m_en, m_stage + 1);
                        if (nx < 0) m_ph = MDone;
                        else begin m_stage = nx; m_wd = 0; end
                    end else if (to != 0 && m_wd == int'(to) - 1) begin
                        m_ph = MErr; m_errst = m_stage; m_low = 1'b0;
                    end else m_wd++;
                end
                MDone: if (abort || !start) m_ph = MIdle;
                MErr: begin
                    if (abort) m_ph = MIdle;
                    else if (!start) m_low = 1'b1;
                    else if (m_low) m_ph = MIdle;
                end
                default: m_ph = MIdle;
            endcase
        end
    end

    // Stimulus helpers: stage responders finish dly[s] cycles after their start.
    int  dly[NS];
    bit  auto_done = 1'b0, rnd_bus = 1'b1;
    int  order[$];
    logic [NS-1:0] prev_start = '0;
    int  leak3 = 0, in_s2 = 0;

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk); #1;
            if (rnd_bus) begin
                for (int i = 0; i < NS*NB; i++) begin
                    stg_we[i] = 1'($urandom_range(0, 1));
                    stg_wdata[i*W +: W] = {$urandom, $urandom};
                    stg_addr[i*AW +: AW] = $urandom;
                end
            end
            stg_done = '0;
            if (auto_done && m_ph == MRun && dly[m_stage] >= 0 && m_wd == dly[m_stage])
                stg_done[m_stage] = 1'b1;
            if (stg_start_o != prev_start && stg_start_o != '0)
                for (int i = 0; i < NS; i++) if (stg_start_o[i]) order.push_back(i);
            prev_start = stg_start_o;
            if (busy_o && (cur_stage_o == 3'd1 || cur_stage_o == 3'd2) &&
                (bar_we_o[3] || bar_addr_o[3*AW +: AW] != '0 || bar_wdata_o[3*W +: W] != '0))
                leak3++;
            if (busy_o && cur_stage_o == 3'd2) in_s2++;
        end
    endtask

    task automatic wait_for(bit want_err, int maxc, string nm);
        int c = 0;
        while (!(want_err ? error_o : done_o) && c < maxc) begin tick(); c++; end
        chk(nm, want_err ? error_o : done_o, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NS; i++) dly[i] = 10;
        tick(3);
        chk("rst_stg_start", stg_start_o, 0);
        chk("rst_run_cycles", run_cycles_o, 0);
        rst_n = 1'b1;
        tick(2);

        // Full run, all stages, 11 cycles each.
        stage_en = 5'h1F; to = '0; auto_done = 1'b1; order.delete(); leak3 = 0;
        start = 1'b1;
        wait_for(1'b0, 200, "t1_reach_done");
        chk("t1_run_cycles", run_cycles_o, 55);
        chk("t1_order_len", order.size(), 5);
        foreach (order[i]) chk("t1_order", order[i], i);
        chk("t1_bar3_leak", leak3, 0);
        start = 1'b0; tick();
        chk("t1_done_clear", done_o, 0);

        // Skipped stages, then empty mask.
        stage_en = 5'b01010; order.delete(); start = 1'b1;
        wait_for(1'b0, 200, "t2_reach_done");
        chk("t2_order_len", order.size(), 2);
        foreach (order[i]) chk("t2_order", order[i], 1 + 2*i);
        chk("t2_run_cycles", run_cycles_o, 22);
        start = 1'b0; tick();
        stage_en = '0; start = 1'b1; tick();
        chk("t2_empty_done", done_o, 1);
        chk("t2_empty_cycles", run_cycles_o, 0);
        start = 1'b0; tick();

        // Watchdog expiry in stage 2.
        stage_en = 5'h1F; to = 24'd8; dly = '{2, 2, -1, 10, 10}; in_s2 = 0; start = 1'b1;
        wait_for(1'b1, 100, "t3_reach_err");
        chk("t3_err_stage", err_stage_o, 2);
        chk("t3_stg_start", stg_start_o, 0);
        chk("t3_bar_we", bar_we_o, 0);
        chk("t3_bar_addr", |bar_addr_o, 0);
        chk("t3_cycles_s2", in_s2, 8);
        chk("t3_run_cycles", run_cycles_o, 14);
        start = 1'b0; tick(2);
        chk("t3_err_held", error_o, 1);
        start = 1'b1; tick();
        chk("t3_err_left", error_o, 0);
        tick();
        chk("t3_restart", busy_o, 1);
        chk("t3_err_stage_clr", err_stage_o, 0);
        abort = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        chk("t3_abort", busy_o, 0);
        tick();

        // abort beats stg_done; stg_done beats watchdog.
        auto_done = 1'b0; to = '0; start = 1'b1; tick(2);
        stg_done = 5'b00001; abort = 1'b1; tick();
        abort = 1'b0; start = 1'b0;
        chk("t4_abort_busy", busy_o, 0);
        chk("t4_abort_stage", cur_stage_o, 0);
        tick();
        auto_done = 1'b1; to = 24'd4; dly = '{3, 3, 3, 3, 3}; start = 1'b1;
        wait_for(1'b0, 100, "t4_reach_done");
        chk("t4_no_error", error_o, 0);
        chk("t4_run_cycles", run_cycles_o, 20);
        start = 1'b0; tick();

        // Ownership: stage 3 does not own bar0, owns bar1.
        auto_done = 1'b0; rnd_bus = 1'b0; to = '0;
        stg_we = '0; stg_wdata = '0; stg_addr = '0;
        stage_en = 5'b01000; start = 1'b1; tick();
        stg_we[12] = 1'b1; stg_addr[12*AW +: AW] = 32'h100;
        stg_we[13] = 1'b1; stg_addr[13*AW +: AW] = 32'h40; stg_wdata[13*W +: W] = 64'hA5;
        #1;
        chk("t5_stage", cur_stage_o, 3);
        chk("t5_bar0_we", bar_we_o[0], 0);
        chk("t5_bar0_addr", bar_addr_o[0 +: AW], 0);
        chk("t5_bar1_we", bar_we_o[1], 1);
        chk("t5_bar1_addr", bar_addr_o[AW +: AW], 32'h40);
        chk("t5_bar1_data", bar_wdata_o[W +: W], 64'hA5);
        tick(); stg_done[3] = 1'b1; tick();
        chk("t5_done", done_o, 1);
        start = 1'b0; rnd_bus = 1'b1; tick();

        // Asynchronous reset during stage 1, then a clean restart.
        auto_done = 1'b1; dly = '{10, 10, 10, 10, 10}; stage_en = 5'h1F; start = 1'b1;
        begin
            int c = 0;
            while (cur_stage_o != 3'd1 && c < 50) begin tick(); c++; end
        end
        chk("t6_reach_s1", cur_stage_o, 1);
        rst_n = 1'b0; start = 1'b0; #1;
        chk("t6_rst_start", stg_start_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_cycles", run_cycles_o, 0);
        chk("t6_rst_stage", cur_stage_o, 0);
        tick(2); rst_n = 1'b1; tick();
        start = 1'b1; tick();
        chk("t6_restart_s0", stg_start_o, 5'b00001);
        abort = 1'b1; tick(); abort = 1'b0; start = 1'b0; tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
